// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, the bubble encoding and the sequential PC step.
package cpu_pkg;
    localparam int PC_W_DEF   = 32;
    localparam int INST_W_DEF = 32;
    localparam int PC_STEP    = 4;
    localparam logic [INST_W_DEF-1:0] INST_BUBBLE = 32'b0;
endpackage

// File: rtl/if_sat_counter.sv
// Enable-driven saturating up-counter; sticks at all-ones until reset.
module if_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register plus IF/ID pipeline register.
// Define IF_PERF_CNT_EN to add saturating stall/flush cycle counters.
module if_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INST_W   = INST_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              taken_i,
    input  logic [PC_W-1:0]   target_i,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic [INST_W-1:0] imem_inst_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [PC_W-1:0]   pc_id_o,
    output logic [INST_W-1:0] inst_id_o,
`ifdef IF_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
`endif
    output logic              flush_id_o
);
    localparam logic [PC_W-1:0]   ALIGN_MASK = ~PC_W'(3);
    localparam logic [INST_W-1:0] BUBBLE     = INST_W'(INST_BUBBLE);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pc_id_q, pc_id_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              flush_q, flush_d;

    // Priority: idle > stall > taken branch > sequential fetch.
    always_comb begin
        pc_d    = pc_q;
        pc_id_d = pc_id_q;
        inst_d  = inst_q;
        flush_d = flush_q;
        if (!start_i) begin
            inst_d  = BUBBLE;
            flush_d = 1'b1;
        end else if (stall_i) begin
            // Branch operands are not ready while stalled, so taken_i is ignored.
        end else if (taken_i) begin
            pc_d    = target_i & ALIGN_MASK;
            pc_id_d = pc_q;
            inst_d  = BUBBLE;
            flush_d = 1'b1;
        end else begin
            pc_d    = pc_q + PC_W'(PC_STEP);
            pc_id_d = pc_q;
            inst_d  = imem_inst_i;
            flush_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC & ALIGN_MASK;
            pc_id_q <= '0;
            inst_q  <= '0;
            flush_q <= 1'b1;
        end else begin
            pc_q    <= pc_d;
            pc_id_q <= pc_id_d;
            inst_q  <= inst_d;
            flush_q <= flush_d;
        end
    end

    assign pc_o        = pc_q;
    assign imem_addr_o = pc_q;
    assign pc_id_o     = pc_id_q;
    assign inst_id_o   = inst_q;
    assign flush_id_o  = flush_q;

`ifdef IF_PERF_CNT_EN
    logic stall_en, flush_en;
    assign stall_en = start_i && stall_i;
    assign flush_en = start_i && taken_i && !stall_i;

    if_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (stall_en),
        .cnt_o (stall_cnt_o)
    );

    if_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (flush_en),
        .cnt_o (flush_cnt_o)
    );
`endif
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, branch, alignment, wrap and async reset.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst, start, stall, taken;
    logic [31:0] target, imem_addr, imem_inst, pc, pc_id, inst_id;
    logic        flush_id;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory stub: every address returns a distinct word.
    assign imem_inst = imem_addr ^ 32'hA5A5_0000;

    if_stage dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stall_i     (stall),
        .taken_i     (taken),
        .target_i    (target),
        .imem_addr_o (imem_addr),
        .imem_inst_i (imem_inst),
        .pc_o        (pc),
        .pc_id_o     (pc_id),
        .inst_id_o   (inst_id),
`ifdef IF_PERF_CNT_EN
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt),
`endif
        .flush_id_o  (flush_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pcid,
                          input logic [31:0] e_inst, input logic e_flush);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".pc_id"}, pc_id, e_pcid);
        chk({tag, ".inst"}, inst_id, e_inst);
        chk({tag, ".flush"}, {31'b0, flush_id}, {31'b0, e_flush});
    endtask

    task automatic chk_cnt(input string tag, input int e_stall, input int e_flush);
`ifdef IF_PERF_CNT_EN
        chk({tag, ".stall_cnt"}, stall_cnt, e_stall);
        chk({tag, ".flush_cnt"}, flush_cnt, e_flush);
`else
        if (e_stall < 0 || e_flush < 0) chk({tag, ".cnt_arg"}, 32'(e_stall), 32'(e_flush));
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; taken = 1'b0; target = '0;
        #3;
        chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b1);
        chk("reset.imem_addr", imem_addr, 32'h0);
        chk_cnt("reset", 0, 0);
        step();
        rst = 1'b0; start = 1'b1;

        // Sequential fetch
        step(); chk_if("seq1", 32'h4, 32'h0, 32'hA5A5_0000, 1'b0);
        chk("seq1.imem_addr", imem_addr, 32'h4);
        step(); chk_if("seq2", 32'h8, 32'h4, 32'hA5A5_0004, 1'b0);

        // Two-cycle stall at pc=8
        stall = 1'b1;
        step(); chk_if("stall1", 32'h8, 32'h4, 32'hA5A5_0004, 1'b0);
        step(); chk_if("stall2", 32'h8, 32'h4, 32'hA5A5_0004, 1'b0);
        chk_cnt("stall2", 2, 0);
        stall = 1'b0;
        step(); chk_if("seq3", 32'hC, 32'h8, 32'hA5A5_0008, 1'b0);

        // Taken branch to 0x40 costs one bubble
        taken = 1'b1; target = 32'h40;
        step(); chk_if("br", 32'h40, 32'hC, 32'h0, 1'b1);
        chk_cnt("br", 2, 1);
        taken = 1'b0;
        step(); chk_if("br_tgt", 32'h44, 32'h40, 32'hA5A5_0040, 1'b0);

        // Stall wins over taken
        stall = 1'b1; taken = 1'b1; target = 32'h80;
        step(); chk_if("stall_br", 32'h44, 32'h40, 32'hA5A5_0040, 1'b0);
        chk_cnt("stall_br", 3, 1);

        // Unaligned target is forced to word alignment
        stall = 1'b0; target = 32'h43;
        step(); chk_if("align", 32'h40, 32'h44, 32'h0, 1'b1);
        chk_cnt("align", 3, 2);

        // Wrap from the top of the address space
        target = 32'hFFFF_FFFC;
        step(); chk("wrap.pc_top", pc, 32'hFFFF_FFFC);
        taken = 1'b0;
        step(); chk_if("wrap", 32'h0, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b0);
        chk_cnt("wrap", 3, 3);

        // Idle: bubbles injected, PC and pc_id hold, counters ignore stall/taken
        start = 1'b0; stall = 1'b1; taken = 1'b1; target = 32'h100;
        step(); chk_if("idle", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
        chk_cnt("idle", 3, 3);
        start = 1'b1; stall = 1'b0; taken = 1'b0;
        step(); chk_if("resume", 32'h4, 32'h0, 32'hA5A5_0000, 1'b0);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        chk_if("async_rst", 32'h0, 32'h0, 32'h0, 1'b1);
        chk_cnt("async_rst", 0, 0);
        step();
        rst = 1'b0; start = 1'b0;
        step(); chk_if("post_rst_idle", 32'h0, 32'h0, 32'h0, 1'b1);
        start = 1'b1;
        step(); chk_if("post_rst_run", 32'h4, 32'h0, 32'hA5A5_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipelined CPU: owns the program counter, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register. Sits upstream of the ID stage and consumes the stall and branch-taken/target signals produced by the hazard detection unit and branch resolution logic in ID. Optionally counts stall and flush cycles so the bench reads them from one place.

## Interface
- PC_W, 32, PC and address width
- INST_W, 32, instruction width
- RESET_PC, 0, PC value after reset
- CNT_W, 32, performance counter width (used only with IF_PERF_CNT_EN)

- clk_i  input  1  clock, rising-edge
- rst_i  input  1  reset; one clock; reset is asynchronous and active-high
- start_i  input  1  run enable; low holds PC and injects bubbles
- stall_i  input  1  load-use stall from hazard detection unit
- taken_i  input  1  branch in ID resolved taken
- target_i  input  PC_W  branch target from ID
- imem_addr_o  output  PC_W  instruction memory address (combinational = pc_o)
- imem_inst_i  input  INST_W  instruction memory read data (combinational read)
- pc_o  output  PC_W  current fetch PC
- pc_id_o  output  PC_W  IF/ID registered PC
- inst_id_o  output  INST_W  IF/ID registered instruction
- flush_id_o  output  1  IF/ID holds a bubble (ID must not write state)
- stall_cnt_o  output  CNT_W  stall cycle count (IF_PERF_CNT_EN only)
- flush_cnt_o  output  CNT_W  flush count (IF_PERF_CNT_EN only)

## Operation
- Reset values: pc_o=RESET_PC, pc_id_o=0, inst_id_o=0, flush_id_o=1, counters=0.
- Per-edge priority, highest first: start_i low > stall_i > taken_i > sequential.
- start_i low: PC holds; IF/ID loads inst=0, flush=1, pc_id holds.
- stall_i high: PC and entire IF/ID register hold (including flush_id_o). taken_i is ignored in the same cycle (branch operands are not ready while stalled).
- taken_i high, stall_i low: PC <= {target_i[PC_W-1:2], 2'b00}; IF/ID loads inst=0, flush=1, pc_id <= pc_o (wrong-path fetch squashed).
- Otherwise: PC <= pc_o + 4, wrapping modulo 2^PC_W; IF/ID loads pc_id <= pc_o, inst <= imem_inst_i, flush <= 0.
- PC bits [1:0] are always 0.

## Timing
- imem_addr_o equals pc_o combinationally; instruction at PC reaches inst_id_o one edge after being addressed.
- Taken branch costs exactly one bubble: target instruction appears in IF/ID on the second edge after taken_i is sampled.
- Stall of N cycles freezes pc_o and IF/ID for exactly N edges.
- rst_i asserted mid-run: all state returns to reset values immediately, without waiting for an edge; first fetch after release is from RESET_PC, with the first valid IF/ID load on the first edge where start_i=1.
- PC at 0xFFFFFFFC with no branch wraps to 0x00000000.

## Configuration
- IF_PERF_CNT_EN defined: stall_cnt_o increments on each edge where start_i && stall_i; flush_cnt_o increments on each edge where start_i && taken_i && !stall_i; both saturate at all-ones and clear only on rst_i.
- Undefined: counters and both ports are absent; no counter logic is synthesised.

## Structure
- Shared package cpu_pkg: INST_BUBBLE (32'b0), PC_STEP (4), PC_W/INST_W defaults.
- One sub-module: if_sat_counter (enable-driven saturating counter, async active-high reset), instantiated twice under IF_PERF_CNT_EN.

## Test plan
- Reset then start_i=1, imem holds distinct words at 0,4,8 -> pc_o steps 0,4,8,12; inst_id_o follows one edge later; flush_id_o drops to 0 after first edge.
- stall_i high for 2 cycles at pc_o=8 -> pc_o stays 8 and IF/ID unchanged for 2 edges; stall_cnt_o=2.
- taken_i with target_i=0x40 at pc_o=12 -> next pc_o=0x40, inst_id_o=0 and flush_id_o=1 for one cycle, then instruction at 0x40; flush_cnt_o=1.
- stall_i and taken_i together -> PC holds, no redirect, flush_cnt_o unchanged, stall_cnt_o +1.
- target_i=0x43 -> pc_o=0x40; PC forced to 0xFFFFFFFC and stepped -> pc_o=0.
- rst_i pulsed between edges mid-run -> pc_o=RESET_PC, flush_id_o=1, counters=0 immediately, before the next clock edge.
